// File: rtl/ps2_pkg.sv
// PS/2 host transmitter shared types and constants.
// Frame: start, 8 data bits LSB first, odd parity, stop, device ACK.
package ps2_pkg;

  typedef enum logic [2:0] {
    IDLE,
    INHIBIT,
    REQ,
    XFER,
    WAIT_IDLE
  } state_t;

  localparam logic [7:0] CMD_SET_LEDS = 8'hED;
  localparam logic [7:0] CMD_RESET    = 8'hFF;
  localparam logic [7:0] CMD_ENABLE   = 8'hF4;
  localparam logic [7:0] RSP_ACK      = 8'hFA;

  localparam int BIT_COUNT = 11;

  function automatic logic odd_parity(input logic [7:0] d);
    return ~^d;
  endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// 2-FF synchronizer plus debounce for one PS/2 line.
// Level changes after FILTER_LEN equal samples; fall pulses on 1->0.
module ps2_line_filter #(
  parameter int FILTER_LEN = 8
) (
  input  logic clock,
  input  logic reset,
  input  logic line_in,
  output logic level,
  output logic fall
);

  localparam int CW = $clog2(FILTER_LEN + 1);
  localparam logic [CW-1:0] LAST = CW'(FILTER_LEN - 1);

  logic          s1;
  logic          s2;
  logic [CW-1:0] cnt;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      s1    <= 1'b1;
      s2    <= 1'b1;
      level <= 1'b1;
      fall  <= 1'b0;
      cnt   <= '0;
    end else begin
      s1   <= line_in;
      s2   <= s1;
      fall <= 1'b0;
      if (s2 == level) begin
        cnt <= '0;
      end else if (cnt == LAST) begin
        cnt   <= '0;
        level <= s2;
        fall  <= level;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device command transmitter with ACK check.
// Drives open-drain CLK/DAT through output enables (1 = pull low).
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int CLK_FREQ_HZ    = 50_000_000,
  parameter int INHIBIT_CYCLES = CLK_FREQ_HZ / 10_000,
  parameter int REQ_CYCLES     = 50,
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = CLK_FREQ_HZ / 1_000 * 15
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  input  logic       ps2_clk_in,
  input  logic       ps2_dat_in,
  output logic       ps2_clk_oe,
  output logic       ps2_dat_oe,
  output logic       busy,
  output logic       done,
  output logic       ack_ok,
  output logic       error
);

  localparam int PH_MAX = (INHIBIT_CYCLES > REQ_CYCLES) ?
                          INHIBIT_CYCLES : REQ_CYCLES;
  localparam int PH_W = $clog2(PH_MAX + 1);
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam int BC_W = $clog2(BIT_COUNT + 1);

  localparam logic [PH_W-1:0] INH_LAST = PH_W'(INHIBIT_CYCLES - 1);
  localparam logic [PH_W-1:0] REQ_LAST = PH_W'(REQ_CYCLES - 1);
  localparam logic [TO_W-1:0] TO_LAST  = TO_W'(TIMEOUT_CYCLES - 1);

  logic clk_lvl, clk_fall, dat_lvl, unused_dat_fall;

  ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_clk_filt (
    .clock   (clock),
    .reset   (reset),
    .line_in (ps2_clk_in),
    .level   (clk_lvl),
    .fall    (clk_fall)
  );

  ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_dat_filt (
    .clock   (clock),
    .reset   (reset),
    .line_in (ps2_dat_in),
    .level   (dat_lvl),
    .fall    (unused_dat_fall)
  );

  state_t          st, st_n;
  logic [PH_W-1:0] ph_cnt, ph_n;
  logic [TO_W-1:0] to_cnt, to_n;
  logic [BC_W-1:0] bit_cnt, bit_n;
  logic [7:0]      data, data_n;
  logic            par, par_n;
  logic            clk_oe_n, dat_oe_n, busy_n, rdy_n;
  logic            done_n, ack_n, err_n;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      st         <= IDLE;
      ph_cnt     <= '0;
      to_cnt     <= '0;
      bit_cnt    <= '0;
      data       <= '0;
      par        <= 1'b0;
      ps2_clk_oe <= 1'b0;
      ps2_dat_oe <= 1'b0;
      busy       <= 1'b0;
      tx_ready   <= 1'b1;
      done       <= 1'b0;
      ack_ok     <= 1'b0;
      error      <= 1'b0;
    end else begin
      st         <= st_n;
      ph_cnt     <= ph_n;
      to_cnt     <= to_n;
      bit_cnt    <= bit_n;
      data       <= data_n;
      par        <= par_n;
      ps2_clk_oe <= clk_oe_n;
      ps2_dat_oe <= dat_oe_n;
      busy       <= busy_n;
      tx_ready   <= rdy_n;
      done       <= done_n;
      ack_ok     <= ack_n;
      error      <= err_n;
    end
  end

  always_comb begin
    st_n     = st;
    ph_n     = ph_cnt;
    to_n     = to_cnt;
    bit_n    = bit_cnt;
    data_n   = data;
    par_n    = par;
    clk_oe_n = ps2_clk_oe;
    dat_oe_n = ps2_dat_oe;
    busy_n   = busy;
    rdy_n    = tx_ready;
    ack_n    = ack_ok;
    done_n   = 1'b0;
    err_n    = 1'b0;
    unique case (st)
      IDLE: begin
        if (tx_valid && tx_ready) begin
          st_n     = INHIBIT;
          data_n   = tx_data;
          par_n    = odd_parity(tx_data);
          ph_n     = '0;
          clk_oe_n = 1'b1;
          busy_n   = 1'b1;
          rdy_n    = 1'b0;
          ack_n    = 1'b0;
        end
      end
      INHIBIT: begin
        if (ph_cnt == INH_LAST) begin
          st_n     = REQ;
          ph_n     = '0;
          dat_oe_n = 1'b1;
        end else begin
          ph_n = ph_cnt + 1'b1;
        end
      end
      REQ: begin
        if (ph_cnt == REQ_LAST) begin
          st_n     = XFER;
          clk_oe_n = 1'b0;
          to_n     = '0;
          bit_n    = '0;
        end else begin
          ph_n = ph_cnt + 1'b1;
        end
      end
      XFER, WAIT_IDLE: begin
        // Timeout wins over any same-cycle completion.
        if (to_cnt == TO_LAST) begin
          st_n     = IDLE;
          clk_oe_n = 1'b0;
          dat_oe_n = 1'b0;
          busy_n   = 1'b0;
          rdy_n    = 1'b1;
          ack_n    = 1'b0;
          err_n    = 1'b1;
        end else begin
          to_n = to_cnt + 1'b1;
          if (st == XFER && clk_fall) begin
            bit_n = bit_cnt + 1'b1;
            unique case (1'b1)
              (bit_cnt < BC_W'(8)):  dat_oe_n = ~data[bit_cnt[2:0]];
              (bit_cnt == BC_W'(8)): dat_oe_n = ~par;
              (bit_cnt == BC_W'(9)): dat_oe_n = 1'b0;
              default: begin
                ack_n = ~dat_lvl;
                st_n  = WAIT_IDLE;
              end
            endcase
          end else if (st == WAIT_IDLE && clk_lvl && dat_lvl) begin
            st_n   = IDLE;
            busy_n = 1'b0;
            rdy_n  = 1'b1;
            done_n = 1'b1;
          end
        end
      end
      default: st_n = IDLE;
    endcase
  end

endmodule
